// File: rtl/sub_bytes_pipe.sv
// rtl/sub_bytes_pipe.sv - pipelined AES SubBytes/InvSubBytes over LANES bytes with valid/ready flow control
module sub_bytes_pipe #(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int INV_EN      = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [8*LANES-1:0]                   in_data,
    input  logic                                 in_inv,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [8*LANES-1:0]                   out_data,
    output logic                                 out_inv,
    output logic [$clog2(PIPE_STAGES+1)-1:0]     count
);
    localparam int W  = 8 * LANES;
    localparam int N  = PIPE_STAGES;
    localparam int CW = $clog2(PIPE_STAGES + 1);

    // Entry 0 sits in the most significant byte so each line reads as one table row.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] x, input logic inv);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
    endfunction

    function automatic logic [W-1:0] sbox_word(input logic [W-1:0] w, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[8*i +: 8] = sbox_byte(w[8*i +: 8], inv);
        end
        return r;
    endfunction

    logic [N-1:0] v_q;
    logic [N-1:0] inv_q;
    logic [W-1:0] data_q [N];
    logic [N-1:0] ld;
    logic         in_inv_eff;
    logic         accept;
    logic [W-1:0] sub_data;

    assign in_inv_eff = (INV_EN != 0) && in_inv;
    assign sub_data   = sbox_word(data_q[0], inv_q[0]);

    // A stage may load when it is empty or everything downstream of it is moving.
    always_comb begin : ready_chain
        logic run;
        run     = out_ready || !v_q[N-1];
        ld      = '0;
        ld[N-1] = run;
        for (int k = N - 2; k >= 0; k--) begin
            run   = run || !v_q[k];
            ld[k] = run;
        end
    end

    assign in_ready = ld[0] && !flush && rst_n;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            inv_q <= '0;
            for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (ld[0]) begin
                v_q[0] <= accept;
                if (accept) begin
                    data_q[0] <= in_data;
                    inv_q[0]  <= in_inv_eff;
                end
            end
            // Registers only capture when the source stage is valid, so bubbles leave data untouched.
            for (int k = 1; k < N; k++) begin
                if (ld[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        data_q[k] <= (k == 1) ? sub_data : data_q[k-1];
                        inv_q[k]  <= inv_q[k-1];
                    end
                end
            end
            if (flush) begin
                v_q <= '0;
            end
        end
    end

    assign out_valid = v_q[N-1];
    assign out_inv   = inv_q[N-1];

    generate
        if (N == 1) begin : g_comb_out
            // Masked so the single-stage build still presents zero data when empty or in reset.
            assign out_data = v_q[0] ? sub_data : '0;
        end else begin : g_reg_out
            assign out_data = data_q[N-1];
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int k = 0; k < N; k++) begin
            count = count + CW'(v_q[k]);
        end
    end
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb/tb_sub_bytes_pipe.sv - randomized self-checking bench for sub_bytes_pipe against a GF(2^8) S-box model
module tb_sub_bytes_pipe;
    localparam int L  = 16;
    localparam int N  = 2;
    localparam int W  = 8 * L;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_inv = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_inv;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;

    sub_bytes_pipe #(.LANES(L), .PIPE_STAGES(N), .INV_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
        .count(count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] s_tab  [256];
    logic [7:0] si_tab [256];
    logic [W:0] pend[$];
    logic [W:0] exp_q[$];
    logic [W:0] got_q[$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h01;
            for (int k = 0; k < 254; k++) b = gmul(b, 8'(x));
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            s_tab[x]  = s;
            si_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) r[8*i +: 8] = inv ? si_tab[d[8*i +: 8]] : s_tab[d[8*i +: 8]];
        return {inv, r};
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Transaction recorder: in-flight model queue plus paired expected/observed outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_inv, out_data});
                if (pend.size() > 0) exp_q.push_back(pend.pop_front());
                else exp_q.push_back({(W+1){1'bx}});
            end
            if (flush) pend.delete();
            else if (in_valid && in_ready) pend.push_back(model(in_data, in_inv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        tick();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        for (n = 0; n < 20; n++) begin
            if (!out_valid && count == '0) break;
            tick();
            #1;
        end
        if (n == 20) begin
            total++;
            $display("FAIL drain_timeout: pipeline still busy, count=%0d", count);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic inv);
        int n;
        tick();
        in_valid = 1'b1; in_data = d; in_inv = inv;
        #1;
        for (n = 0; n < 20 && !in_ready; n++) begin
            tick();
            #1;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: in_ready stayed 0");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
        total++; if (out_inv !== 1'b0) $display("FAIL reset_out_inv: got %b want 0", out_inv); else passed++;
        total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_forward_sweep();
        logic [7:0] ins [9];
        logic [7:0] outs [9];
        ins  = '{8'h00, 8'h23, 8'h56, 8'ha3, 8'h4e, 8'h19, 8'hff, 8'hcc, 8'hdf};
        outs = '{8'h63, 8'h26, 8'hb1, 8'h0a, 8'h2f, 8'hd4, 8'h16, 8'h4b, 8'h9e};
        out_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            in_valid = (c < 9);
            in_inv   = 1'b0;
            if (c < 9) in_data = {L{ins[c]}};
            #1;
            if (c == 1) begin
                total++; if (out_valid !== 1'b0) $display("FAIL sweep_early_valid: got %b want 0", out_valid); else passed++;
            end
            if (c >= 2) begin
                total++; if (out_valid !== 1'b1) $display("FAIL sweep_valid[%0d]: got %b want 1", c, out_valid); else passed++;
                total++; if (out_data !== {L{outs[c-2]}}) $display("FAIL sweep_data[%0d]: got %h want %h", c - 2, out_data, {L{outs[c-2]}}); else passed++;
            end
            if (c >= 2 && c <= 9) begin
                total++; if (count !== CW'(2)) $display("FAIL sweep_count[%0d]: got %0d want 2", c, count); else passed++;
            end
        end
        drain();
    endtask

    task automatic test_inverse();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            in_valid = (c < 2);
            in_inv   = 1'b1;
            in_data  = (c == 0) ? {L{8'h63}} : {L{8'h16}};
            #1;
            if (c >= 2) begin
                total++; if (out_valid !== 1'b1) $display("FAIL inv_valid[%0d]: got %b want 1", c, out_valid); else passed++;
                total++; if (out_inv !== 1'b1) $display("FAIL inv_flag[%0d]: got %b want 1", c, out_inv); else passed++;
                total++;
                if (out_data !== ((c == 2) ? {L{8'h00}} : {L{8'hff}}))
                    $display("FAIL inv_data[%0d]: got %h want %h", c, out_data, (c == 2) ? {L{8'h00}} : {L{8'hff}});
                else passed++;
            end
        end
        in_inv = 1'b0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d [3];
        logic [W-1:0] held;
        logic [W:0]   want;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 3; i++) d[i] = rand_word();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            in_valid = 1'b1; in_inv = 1'b0; in_data = d[i];
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL bp_accept[%0d]: in_ready got %b want 1", i, in_ready); else passed++;
        end
        tick();
        in_data = d[2];
        #1;
        held = out_data;
        want = model(d[0], 1'b0);
        total++; if (out_data !== want[W-1:0]) $display("FAIL bp_head_data: got %h want %h", out_data, want[W-1:0]); else passed++;
        for (int c = 0; c < 4; c++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready[%0d]: got %b want 0", c, in_ready); else passed++;
            total++; if (count !== CW'(2)) $display("FAIL bp_full_count[%0d]: got %0d want 2", c, count); else passed++;
            total++; if (out_data !== held) $display("FAIL bp_stable[%0d]: got %h want %h", c, out_data, held); else passed++;
            tick();
            #1;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL full_stream_ready: got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (count !== CW'(2)) $display("FAIL full_stream_count: got %0d want 2", count); else passed++;
        drain();
        total++; if (got_q.size() !== 3) $display("FAIL bp_out_count: got %0d want 3", got_q.size()); else passed++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            want = model(d[i], 1'b0);
            total++; if (got_q[i] !== want) $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], want); else passed++;
        end
    endtask

    task automatic test_flush();
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            in_valid = 1'b1; in_inv = 1'b0; in_data = rand_word();
        end
        tick();
        in_data = rand_word();
        flush = 1'b1;
        #1;
        total++; if (count !== CW'(2)) $display("FAIL flush_pre_count: got %0d want 2", count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (count !== '0) $display("FAIL flush_count: got %0d want 0", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else passed++;
        out_ready = 1'b1;
        repeat (4) tick();
        total++; if (got_q.size() !== 0) $display("FAIL flush_leak: got %0d outputs want 0", got_q.size()); else passed++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            in_valid = 1'b1; in_data = rand_word(); in_inv = 1'($urandom_range(0, 1));
        end
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL mid_rst_data: got %h want 0", out_data); else passed++;
        total++; if (count !== '0) $display("FAIL mid_rst_count: got %0d want 0", count); else passed++;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = '0; in_inv = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL post_rst_idle: got %b want 0", out_valid); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL post_rst_latency: got %b want 0", out_valid); else passed++;
        tick();
        #1;
        total++; if (out_valid !== 1'b1) $display("FAIL post_rst_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_data !== {L{8'h63}}) $display("FAIL post_rst_data: got %h want %h", out_data, {L{8'h63}}); else passed++;
        drain();
    endtask

    task automatic test_random();
        logic [W-1:0]  prev_data;
        logic          prev_inv;
        logic          prev_stall;
        logic [CW-1:0] want_cnt;
        exp_q.delete(); got_q.delete();
        prev_stall = 1'b0; prev_data = '0; prev_inv = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rand_word();
            in_inv    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            want_cnt = CW'(pend.size());
            total++; if (count !== want_cnt) $display("FAIL rand_count[%0d]: got %0d want %0d", c, count, want_cnt); else passed++;
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_inv !== prev_inv)
                    $display("FAIL rand_hold[%0d]: got %b/%b/%h want 1/%b/%h", c, out_valid, out_inv, out_data, prev_inv, prev_data);
                else passed++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_inv   = out_inv;
        end
        drain();
        total++; if (pend.size() !== 0) $display("FAIL rand_lost: got %0d undelivered want 0", pend.size()); else passed++;
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else passed++;
        end
    endtask

    task automatic test_roundtrip();
        logic [W-1:0] orig [256];
        logic [W-1:0] mid  [256];
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 256; i++) begin
            orig[i] = rand_word();
            send(orig[i], 1'b0);
        end
        drain();
        total++; if (got_q.size() !== 256) $display("FAIL rt_fwd_count: got %0d want 256", got_q.size()); else passed++;
        for (int i = 0; i < 256; i++) begin
            mid[i] = (i < got_q.size()) ? got_q[i][W-1:0] : '0;
            if (i < got_q.size()) begin
                total++; if (got_q[i] !== exp_q[i]) $display("FAIL rt_fwd[%0d]: got %h want %h", i, got_q[i], exp_q[i]); else passed++;
            end
        end
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 256; i++) send(mid[i], 1'b1);
        drain();
        total++; if (got_q.size() !== 256) $display("FAIL rt_inv_count: got %0d want 256", got_q.size()); else passed++;
        for (int i = 0; i < 256 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== {1'b1, orig[i]}) $display("FAIL rt_inv[%0d]: got %h want %h", i, got_q[i], {1'b1, orig[i]}); else passed++;
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_forward_sweep();
        test_inverse();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        test_roundtrip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/sub_bytes_pipe.md
# sub_bytes_pipe

Parametrised, pipelined AES byte-substitution unit. It applies the forward S-box, or optionally the inverse S-box, to LANES independent bytes per transaction. Transactions move through a valid/ready pipeline with backpressure. The unit sits between the round-key adder and ShiftRows in the round datapath, and serves encrypt and decrypt rounds selected per transaction. It supersedes the single-byte combinational S-box.

## Interface
Parameters:
- LANES, 16: bytes substituted per transaction (1..16).
- PIPE_STAGES, 2: register stages from accept to output (1..4).
- INV_EN, 1: 1 = inverse table present; 0 = `in_inv` ignored and treated as 0.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; when high, all stage valid bits clear at the next edge.
- in_valid  in  1  input transaction present.
- in_ready  out  1  unit can accept a transaction this cycle.
- in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i].
- in_inv  in  1  1 = inverse S-box, 0 = forward.
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts.
- out_data  out  8*LANES  substituted bytes; lane i maps lane i.
- out_inv  out  1  mode bit carried with the transaction.
- count  out  $clog2(PIPE_STAGES+1)  transactions currently in flight.

## Operation
- Each stage k holds v[k], data[k] and inv[k]. Stage 1 is the accept stage and stage PIPE_STAGES is the output stage.
- The S-box lookup sits combinationally between stage 1 and stage 2. When PIPE_STAGES=1, the lookup drives `out_data` combinationally from stage 1. Stages after the lookup carry the substituted bytes unchanged.
- Per-lane function: forward = AES SubBytes table; inverse = AES InvSubBytes table. InvS(S(x)) = x for every x.
- Bubble-collapsing advance rule:
  - The output stage can load when `!v[N] || out_ready`.
  - Stage k (k<N) can load when `!v[k] || (stage k+1 can load)`.
  - `in_ready` = stage 1 can load. This is a combinational path from `out_ready`.
- Accept when `in_valid && in_ready`. Output handshake when `out_valid && out_ready`.
- A stage that cannot load holds its contents unchanged.
- `count` = number of set v[k]:
  - +1 on accept only.
  - −1 on output handshake only.
  - Unchanged when both happen in the same cycle.
- `flush` has priority over accept in its cycle:
  - All v[k] go to 0 and `count` goes to 0.
  - An input presented in the flush cycle is not accepted, and `in_ready` is forced to 0 that cycle.
  - `out_valid` may be high during the flush cycle; a handshake in that cycle is valid.
- Transactions exit in acceptance order; none is dropped or duplicated except by flush or reset.

## Timing
- Reset (asynchronous assert, synchronous-style deassert):
  - All v[k]=0; data and inv registers = 0.
  - `out_valid`=0, `out_data`=0, `out_inv`=0, `count`=0.
  - `in_ready`=1 once `rst_n` is high.
- Latency: a transaction accepted at edge t is presented on `out_valid` after edge t+PIPE_STAGES−1 (visible in cycle t+PIPE_STAGES−1 to t+PIPE_STAGES) when there are no stalls.
- Throughput: 1 transaction per cycle with `out_ready` held high.
- Full pipeline (`count`==PIPE_STAGES) with `out_ready`=0: `in_ready`=0 and all stages hold.
- Full pipeline with `out_ready`=1: `in_ready`=1 in the same cycle. The pipeline stays full and streams.
- Empty pipeline: `out_valid`=0; `out_data` holds its last value and is don't-care.
- Reset asserted mid-stream: in-flight transactions are lost immediately and outputs return to reset values.
- `out_data` and `out_inv` must be stable while `out_valid && !out_ready`.

## Test plan
- Forward sweep, LANES=1, PIPE_STAGES=2, `out_ready`=1: inputs 00, 23, 56, A3, 4E, 19, FF, CC, DF on consecutive cycles -> outputs 63, 26, B1, 0A, 2F, D4, 16, 4B, 9E. The first output appears 2 cycles after the first accept, and `count` stays at 2 while streaming.
- Inverse mode, LANES=16: `in_inv`=1 with all lanes 63, then all lanes 16 -> all lanes 00, then all lanes FF, with `out_inv`=1. Separately, a forward pass fed back through inverse returns the original 128-bit word for 256 random words.
- Backpressure: hold `out_ready`=0 and offer 3 transactions -> exactly PIPE_STAGES are accepted, `in_ready`=0, `count`=2, and `out_data` is stable. Release `out_ready` -> outputs appear in order with no loss.
- Simultaneous accept and handshake with a full pipeline -> `count` unchanged and `in_ready`=1 in that cycle.
- `flush` with `count`=2 and `in_valid`=1 -> next cycle `count`=0, `out_valid`=0, and the offered input is not accepted.
- Assert `rst_n`=0 mid-stream for one cycle -> `out_valid`=0, `out_data`=0 and `count`=0 immediately. After release, a single input 00 yields 63 with nominal latency.
